// File: rtl/mem_rd_arbiter_if.sv
// AXI read channel bundle (AR + R, 32-bit data) used for both requester ports and the memory port.
interface mem_rd_arbiter_if #(
   parameter int ID_W = 4
);
   logic            arvalid;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic [1:0]      arburst;
   logic [2:0]      arsize;
   logic            arready;
   logic            rvalid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic [ID_W-1:0] rid;
   logic            rlast;
   logic            rready;

   modport master (output arvalid, araddr, arid, arlen, arburst, arsize, rready,
                   input  arready, rvalid, rdata, rresp, rid, rlast);
   // Requesters do not supply arsize; the arbiter always issues 4-byte beats.
   modport slave  (input  arvalid, araddr, arid, arlen, arburst, rready,
                   output arready, rvalid, rdata, rresp, rid, rlast);
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-requester AXI read arbiter: one whole burst per grant, R beats steered to the owner until RLAST.
//  state | meaning
//  IDLE  | no owner; grant decided from pending arvalid on the next edge
//  ADDR  | AR of grant_q forwarded, waiting for axi arready
//  DATA  | R beats steered to grant_q until the RLAST handshake
module mem_rd_arbiter #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int ID_W       = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_rd_arbiter_if.slave  m0,
   mem_rd_arbiter_if.slave  m1,
   mem_rd_arbiter_if.master axi
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

   state_e state_q, state_d;
   logic   grant_q, grant_d;
   logic   prio_q, prio_d;
   logic   rready_sel;
   logic   burst_done;

   assign rready_sel = grant_q ? m1.rready : m0.rready;
   assign burst_done = (state_q == DATA) && axi.rvalid && rready_sel && axi.rlast;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      prio_d  = prio_q;
      case (state_q)
         IDLE: begin
            if (m0.arvalid || m1.arvalid) begin
               state_d = ADDR;
               if (m0.arvalid && m1.arvalid) grant_d = FIXED_PRIO ? 1'b0 : prio_q;
               else                          grant_d = m1.arvalid;
            end
         end
         ADDR: begin
            if (axi.arready) state_d = DATA;
         end
         DATA: begin
            // The requester that just finished yields to the other one next time.
            if (burst_done) begin
               state_d = IDLE;
               prio_d  = ~grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      axi.arvalid = (state_q == ADDR);
      axi.araddr  = grant_q ? m1.araddr  : m0.araddr;
      axi.arid    = grant_q ? m1.arid    : m0.arid;
      axi.arlen   = grant_q ? m1.arlen   : m0.arlen;
      axi.arburst = grant_q ? m1.arburst : m0.arburst;
      axi.arsize  = 3'd2;
      axi.rready  = 1'b0;
      m0.arready  = 1'b0;
      m1.arready  = 1'b0;
      m0.rvalid   = 1'b0;
      m1.rvalid   = 1'b0;
      m0.rlast    = 1'b0;
      m1.rlast    = 1'b0;
      m0.rdata    = axi.rdata;
      m1.rdata    = axi.rdata;
      m0.rresp    = axi.rresp;
      m1.rresp    = axi.rresp;
      m0.rid      = axi.rid;
      m1.rid      = axi.rid;
      if (state_q == ADDR) begin
         m0.arready = ~grant_q & axi.arready;
         m1.arready =  grant_q & axi.arready;
      end
      if (state_q == DATA) begin
         axi.rready = rready_sel;
         m0.rvalid  = ~grant_q & axi.rvalid;
         m1.rvalid  =  grant_q & axi.rvalid;
         m0.rlast   = ~grant_q & axi.rlast;
         m1.rlast   =  grant_q & axi.rlast;
      end
   end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus; sel picks the one observed.
module tb_mem_rd_arbiter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic [1:0]  m_arvalid, m_rready;
   logic [31:0] m_araddr  [2];
   logic [3:0]  m_arid    [2];
   logic [7:0]  m_arlen   [2];
   logic [1:0]  m_arburst [2];
   logic        axi_arready, axi_rvalid, axi_rlast;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic [3:0]  axi_rid;

   logic [1:0]  o_arvalid, o_rready;
   logic [31:0] o_araddr  [2];
   logic [3:0]  o_arid    [2];
   logic [7:0]  o_arlen   [2];
   logic [1:0]  o_arburst [2];
   logic [2:0]  o_arsize  [2];
   logic [1:0]  o_m_arready [2];
   logic [1:0]  o_m_rvalid  [2];
   logic [1:0]  o_m_rlast   [2];
   logic [31:0] o_m_rdata [2][2];
   logic [1:0]  o_m_rresp [2][2];
   logic [3:0]  o_m_rid   [2][2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_rd_arbiter_if #(.ID_W(4)) m_if [2] ();
      mem_rd_arbiter_if #(.ID_W(4)) axi_if ();
      for (genvar r = 0; r < 2; r++) begin : g_req
         assign m_if[r].arvalid    = m_arvalid[r];
         assign m_if[r].araddr     = m_araddr[r];
         assign m_if[r].arid       = m_arid[r];
         assign m_if[r].arlen      = m_arlen[r];
         assign m_if[r].arburst    = m_arburst[r];
         assign m_if[r].arsize     = 3'd2;
         assign m_if[r].rready     = m_rready[r];
         assign o_m_arready[g][r]  = m_if[r].arready;
         assign o_m_rvalid[g][r]   = m_if[r].rvalid;
         assign o_m_rlast[g][r]    = m_if[r].rlast;
         assign o_m_rdata[g][r]    = m_if[r].rdata;
         assign o_m_rresp[g][r]    = m_if[r].rresp;
         assign o_m_rid[g][r]      = m_if[r].rid;
      end
      assign axi_if.arready = axi_arready;
      assign axi_if.rvalid  = axi_rvalid;
      assign axi_if.rdata   = axi_rdata;
      assign axi_if.rresp   = axi_rresp;
      assign axi_if.rid     = axi_rid;
      assign axi_if.rlast   = axi_rlast;
      assign o_arvalid[g]   = axi_if.arvalid;
      assign o_araddr[g]    = axi_if.araddr;
      assign o_arid[g]      = axi_if.arid;
      assign o_arlen[g]     = axi_if.arlen;
      assign o_arburst[g]   = axi_if.arburst;
      assign o_arsize[g]    = axi_if.arsize;
      assign o_rready[g]    = axi_if.rready;

      mem_rd_arbiter #(.FIXED_PRIO(g == 1), .ID_W(4)) u_dut (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .m0    (m_if[0]),
         .m1    (m_if[1]),
         .axi   (axi_if)
      );
   end

   int sel = 0;
   int beats [2];
   int lasts [2];
   int ar_pulses [2];
   int n_chk = 0;
   int n_err = 0;

   always @(posedge clk_i) begin
      for (int r = 0; r < 2; r++) begin
         if (o_m_rvalid[sel][r] && m_rready[r]) beats[r]++;
         if (o_m_rvalid[sel][r] && o_m_rlast[sel][r] && m_rready[r]) lasts[r]++;
         if (o_m_arready[sel][r] && m_arvalid[r]) ar_pulses[r]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clr_counts();
      for (int r = 0; r < 2; r++) begin
         beats[r] = 0; lasts[r] = 0; ar_pulses[r] = 0;
      end
   endtask

   // Serves one burst from the observed arbiter; g is the requester expected to own it.
   task automatic burst(input string tag, input int g, input logic [31:0] addr, input int nbeats,
                        input int ar_wait, input int stall, input bit drop);
      int n;
      logic [1:0] own;
      own = (g == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (!o_arvalid[sel] && n < 20) begin
         @(negedge clk_i); #1;
         n++;
      end
      check({tag, " arvalid"}, o_arvalid[sel], 1);
      check({tag, " araddr"}, o_araddr[sel], addr);
      check({tag, " arfields"}, {o_arid[sel], o_arlen[sel], o_arburst[sel], o_arsize[sel]},
            {m_arid[g], m_arlen[g], m_arburst[g], 3'd2});
      repeat (ar_wait) begin
         check({tag, " hold"}, {o_arvalid[sel], o_m_arready[sel]}, 3'b100);
         check({tag, " hold addr"}, o_araddr[sel], addr);
         check({tag, " hold fields"}, {o_arid[sel], o_arlen[sel], o_arburst[sel]},
               {m_arid[g], m_arlen[g], m_arburst[g]});
         @(negedge clk_i); #1;
      end
      axi_arready = 1'b1;
      #1;
      check({tag, " arready"}, o_m_arready[sel], own);
      @(negedge clk_i);
      axi_arready = 1'b0;
      if (drop) m_arvalid[g] = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         axi_rvalid = 1'b1;
         axi_rdata  = addr + 32'(i * 4);
         axi_rresp  = (i == 1) ? 2'b10 : 2'b00;
         axi_rid    = m_arid[g];
         axi_rlast  = (i == nbeats - 1);
         if (i == stall) begin
            m_rready[g] = 1'b0;
            #1;
            check({tag, " stall rready"}, o_rready[sel], 0);
            check({tag, " stall rvalid"}, o_m_rvalid[sel], own);
            @(negedge clk_i);
            m_rready[g] = 1'b1;
         end
         #1;
         check({tag, " beat"}, {o_m_rvalid[sel], o_rready[sel]}, {own, 1'b1});
         check({tag, " rdata"}, o_m_rdata[sel][g], addr + 32'(i * 4));
         check({tag, " rresp rid"}, {o_m_rresp[sel][g], o_m_rid[sel][g]},
               {((i == 1) ? 2'b10 : 2'b00), m_arid[g]});
         check({tag, " rlast"}, o_m_rlast[sel], (i == nbeats - 1) ? own : 2'b00);
         @(negedge clk_i);
      end
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      #1;
      check({tag, " idle gap"}, o_arvalid[sel], 0);
   endtask

   initial begin
      m_arvalid = 2'b00; m_rready = 2'b11;
      m_araddr[0] = 32'h0; m_araddr[1] = 32'h0;
      m_arid[0] = 4'h3; m_arid[1] = 4'h9;
      m_arlen[0] = 8'd0; m_arlen[1] = 8'd0;
      m_arburst[0] = 2'b01; m_arburst[1] = 2'b01;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
      axi_rdata = 32'h0; axi_rresp = 2'b00; axi_rid = 4'h0;
      clr_counts();
      #3;
      check("reset outputs", {o_arvalid, o_rready, o_m_arready[0], o_m_rvalid[0]}, 8'h00);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Stray R beat while idle must be ignored.
      axi_rvalid = 1'b1; axi_rlast = 1'b1;
      #1;
      check("idle rvalid", {o_rready[0], o_m_rvalid[0], o_m_rlast[0]}, 5'b0);
      @(negedge clk_i);
      axi_rvalid = 1'b0; axi_rlast = 1'b0;
      #1;
      check("idle stays", o_arvalid[0], 0);

      // 1: m0 alone, 8 beats
      clr_counts();
      m_araddr[0] = 32'h0000_1000; m_arlen[0] = 8'd7; m_arvalid[0] = 1'b1;
      #1;
      check("t1 ar same cycle", o_arvalid[0], 0);
      @(negedge clk_i); #1;
      check("t1 ar next cycle", o_arvalid[0], 1);
      burst("t1", 0, 32'h0000_1000, 8, 0, -1, 1'b1);
      check("t1 m0 beats", beats[0], 8);
      check("t1 m1 beats", beats[1], 0);

      // 4: downstream arready held low for 5 cycles
      clr_counts();
      m_araddr[0] = 32'h0000_2000; m_arlen[0] = 8'd3; m_arburst[0] = 2'b10; m_arvalid[0] = 1'b1;
      burst("t4", 0, 32'h0000_2000, 4, 5, -1, 1'b1);
      check("t4 arready pulses", ar_pulses[0], 1);

      // 5: m1 stalls rready mid-burst
      clr_counts();
      m_araddr[1] = 32'h0000_5000; m_arlen[1] = 8'd7; m_arvalid[1] = 1'b1;
      burst("t5", 1, 32'h0000_5000, 8, 0, 3, 1'b1);
      check("t5 m1 beats", beats[1], 8);
      check("t5 m1 rlast count", lasts[1], 1);

      // 2: both requesting continuously, round-robin
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      m_araddr[0] = 32'h0000_A000; m_arlen[0] = 8'd1; m_arburst[0] = 2'b01;
      m_araddr[1] = 32'h0000_B000; m_arlen[1] = 8'd2;
      m_arvalid = 2'b11;
      burst("t2 b0", 0, 32'h0000_A000, 2, 0, -1, 1'b0);
      burst("t2 b1", 1, 32'h0000_B000, 3, 0, -1, 1'b0);
      burst("t2 b2", 0, 32'h0000_A000, 2, 0, -1, 1'b0);
      burst("t2 b3", 1, 32'h0000_B000, 3, 0, -1, 1'b0);
      m_arvalid = 2'b00;

      // 3: same with fixed priority
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      sel = 1;
      m_arvalid = 2'b11;
      for (int b = 0; b < 4; b++) burst("t3", 0, 32'h0000_A000, 2, 0, -1, 1'b0);
      m_arvalid = 2'b00;

      // 6: reset at beat 3 of 8, then a fresh m1 request
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      sel = 0;
      m_araddr[0] = 32'h0000_3000; m_arlen[0] = 8'd7; m_arvalid[0] = 1'b1;
      @(negedge clk_i);
      axi_arready = 1'b1;
      @(negedge clk_i);
      axi_arready = 1'b0; m_arvalid[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         axi_rvalid = 1'b1; axi_rdata = 32'h0000_3000 + 32'(i * 4); axi_rlast = 1'b0;
         #1;
         check("t6 pre beat", o_m_rvalid[0], 2'b01);
         @(negedge clk_i);
      end
      axi_rvalid = 1'b1;
      rst_i = 1'b1;
      #1;
      check("t6 reset outs", {o_arvalid[0], o_rready[0], o_m_rvalid[0], o_m_arready[0]}, 6'b0);
      @(negedge clk_i);
      rst_i = 1'b0; axi_rvalid = 1'b0;
      #1;
      check("t6 idle", {o_arvalid[0], o_m_rvalid[0]}, 3'b0);
      m_araddr[1] = 32'h0000_4000; m_arlen[1] = 8'd1; m_arvalid[1] = 1'b1;
      burst("t6 m1", 1, 32'h0000_4000, 2, 0, -1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
